phase_counter: RTL and testbench

Parametrised programmable-modulus up/down counter with built-in prescaler, terminal-count pulse and wrap/saturate mode. It is the general timing primitive for the traffic-light controller: phase durations, yellow/all-red intervals and pedestrian timers. With default parameters, `dir=1`, `en=1` and `limit` all-ones, it behaves as a plain free-running binary counter.

---
 rtl/phase_counter.sv | 77 +++++++
 tb/tb_phase_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_counter.sv
// Programmable-modulus up/down counter with enable prescaler, terminal-count
// pulse and selectable wrap or saturate behaviour at the terminal value.
module phase_counter #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [WIDTH-1:0] q_reg, q_next;
    logic [PW-1:0]    pre_reg, pre_next;
    logic             tc_reg, tc_next;
    logic             pre_last;
    logic             step;
    logic             term;

    assign pre_last = (pre_reg == PRE_LAST);
    assign step     = en && pre_last;

    // Counting up, anything at or beyond limit (e.g. after an oversized load)
    // is terminal; counting down only zero is.
    assign term = dir ? (q_reg >= limit) : (q_reg == '0);

    always_comb begin
        q_next   = q_reg;
        pre_next = pre_reg;
        tc_next  = 1'b0;
        if (clear) begin
            q_next   = '0;
            pre_next = '0;
        end else if (load) begin
            q_next   = load_val;
            pre_next = '0;
        end else begin
            if (en) begin
                pre_next = pre_last ? '0 : pre_reg + PW'(1);
            end
            if (step) begin
                tc_next = term;
                if (!term) begin
                    q_next = dir ? q_reg + WIDTH'(1) : q_reg - WIDTH'(1);
                end else if (SATURATE == 0) begin
                    q_next = dir ? '0 : limit;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg   <= '0;
            pre_reg <= '0;
            tc_reg  <= 1'b0;
        end else begin
            q_reg   <= q_next;
            pre_reg <= pre_next;
            tc_reg  <= tc_next;
        end
    end

    assign q  = q_reg;
    assign tc = tc_reg;

endmodule

// File: tb/tb_phase_counter.sv
// Directed bench for phase_counter: four instances cover wrap, prescale-by-4,
// saturate and prescale-by-3 configurations, sharing one set of inputs.
module tb_phase_counter;

    logic       clk = 1'b0;
    logic       reset, clear, load, en, dir;
    logic [5:0] load_val, limit;

    logic [5:0] q_base, q_pre4, q_sat, q_pre3;
    logic       tc_base, tc_pre4, tc_sat, tc_pre3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    phase_counter #(.WIDTH(6), .PRESCALE(1), .SATURATE(0)) u_base (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .limit(limit), .q(q_base), .tc(tc_base));

    phase_counter #(.WIDTH(6), .PRESCALE(4), .SATURATE(0)) u_pre4 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .limit(limit), .q(q_pre4), .tc(tc_pre4));

    phase_counter #(.WIDTH(6), .PRESCALE(1), .SATURATE(1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .limit(limit), .q(q_sat), .tc(tc_sat));

    phase_counter #(.WIDTH(6), .PRESCALE(3), .SATURATE(0)) u_pre3 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .dir(dir), .limit(limit), .q(q_pre3), .tc(tc_pre3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; en = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;
        en = 1'b1; dir = 1'b1; limit = 6'd63;
        tick();
        checks++;
        if (q_base !== 6'd0 || tc_base !== 1'b0) begin
            errors++;
            $display("FAIL reset_base: q=%0d tc=%0b, expected q=0 tc=0", q_base, tc_base);
        end
        checks++;
        if (q_pre4 !== 6'd0 || q_sat !== 6'd0 || q_pre3 !== 6'd0) begin
            errors++;
            $display("FAIL reset_all: q_pre4=%0d q_sat=%0d q_pre3=%0d, expected 0", q_pre4, q_sat, q_pre3);
        end
        $display("reset: q_base=%0d tc_base=%0b", q_base, tc_base);
    endtask

    task automatic test_free_run();
        int exp_q;
        logic exp_tc;
        do_reset();
        limit = 6'd63; dir = 1'b1; en = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            exp_q  = k % 64;
            exp_tc = (k == 64);
            checks++;
            if (q_base !== 6'(exp_q) || tc_base !== exp_tc) begin
                errors++;
                $display("FAIL free_run[%0d]: q=%0d tc=%0b, expected q=%0d tc=%0b", k, q_base, tc_base, exp_q, exp_tc);
            end
        end
        $display("free_run: 70 cycles, final q=%0d", q_base);
    endtask

    task automatic test_prescale();
        int exp_q;
        logic exp_tc;
        do_reset();
        limit = 6'd9; dir = 1'b1; en = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            tick();
            exp_q  = (k / 4) % 10;
            exp_tc = (k == 40);
            checks++;
            if (q_pre4 !== 6'(exp_q) || tc_pre4 !== exp_tc) begin
                errors++;
                $display("FAIL prescale[%0d]: q=%0d tc=%0b, expected q=%0d tc=%0b", k, q_pre4, tc_pre4, exp_q, exp_tc);
            end
        end
        $display("prescale: 44 cycles, final q=%0d", q_pre4);
    endtask

    task automatic test_down_saturate();
        logic [5:0] exp_q [5]  = '{6'd2, 6'd1, 6'd0, 6'd0, 6'd0};
        logic       exp_tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        limit = 6'd9; load_val = 6'd3; load = 1'b1; en = 1'b1; dir = 1'b0;
        tick();
        load = 1'b0;
        checks++;
        if (q_sat !== 6'd3 || tc_sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_load: q=%0d tc=%0b, expected q=3 tc=0", q_sat, tc_sat);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (q_sat !== exp_q[k] || tc_sat !== exp_tc[k]) begin
                errors++;
                $display("FAIL sat_down[%0d]: q=%0d tc=%0b, expected q=%0d tc=%0b", k, q_sat, tc_sat, exp_q[k], exp_tc[k]);
            end
        end
        $display("down_saturate: final q=%0d tc=%0b", q_sat, tc_sat);
    endtask

    task automatic test_load_over_limit();
        do_reset();
        limit = 6'd5; load_val = 6'd12; load = 1'b1; en = 1'b0; dir = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (q_base !== 6'd12) begin
            errors++;
            $display("FAIL over_load: q=%0d, expected 12", q_base);
        end
        en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (q_base !== 6'd0 || tc_base !== 1'b1) begin
            errors++;
            $display("FAIL over_up: q=%0d tc=%0b, expected q=0 tc=1", q_base, tc_base);
        end
        load = 1'b1;
        tick();
        load = 1'b0; dir = 1'b0; en = 1'b1;
        tick();
        en = 1'b0;
        checks++;
        if (q_base !== 6'd11 || tc_base !== 1'b0) begin
            errors++;
            $display("FAIL over_down: q=%0d tc=%0b, expected q=11 tc=0", q_base, tc_base);
        end
        $display("load_over_limit: q=%0d tc=%0b", q_base, tc_base);
    endtask

    task automatic test_en_gaps();
        logic pattern [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [5:0] exp_q [6] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd1};
        do_reset();
        limit = 6'd63; dir = 1'b1;
        for (int k = 0; k < 6; k++) begin
            en = pattern[k];
            tick();
            checks++;
            if (q_pre3 !== exp_q[k]) begin
                errors++;
                $display("FAIL en_gap[%0d]: q=%0d, expected %0d", k, q_pre3, exp_q[k]);
            end
        end
        en = 1'b0;
        $display("en_gaps: final q=%0d", q_pre3);
    endtask

    task automatic test_priority();
        do_reset();
        limit = 6'd63; dir = 1'b1; en = 1'b1;
        repeat (5) tick();
        load = 1'b1; load_val = 6'd7; clear = 1'b1;
        tick();
        load = 1'b0; clear = 1'b0;
        checks++;
        if (q_base !== 6'd0) begin
            errors++;
            $display("FAIL clear_over_load: q=%0d, expected 0", q_base);
        end
        limit = 6'd3;
        repeat (3) tick();
        checks++;
        if (q_base !== 6'd3) begin
            errors++;
            $display("FAIL pre_wrap: q=%0d, expected 3", q_base);
        end
        load = 1'b1;
        tick();
        load = 1'b0;
        checks++;
        if (q_base !== 6'd7 || tc_base !== 1'b0) begin
            errors++;
            $display("FAIL load_on_wrap: q=%0d tc=%0b, expected q=7 tc=0", q_base, tc_base);
        end
        limit = 6'd63; clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (37) tick();
        checks++;
        if (q_base !== 6'd37) begin
            errors++;
            $display("FAIL mid_count: q=%0d, expected 37", q_base);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (q_base !== 6'd0 || tc_base !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: q=%0d tc=%0b, expected q=0 tc=0", q_base, tc_base);
        end
        $display("priority: q=%0d tc=%0b", q_base, tc_base);
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_prescale();
        test_down_saturate();
        test_load_over_limit();
        test_en_gaps();
        test_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
